// File: rtl/hud_text_overlay.sv
// HUD text overlay: game-phase FSM, M:SS countdown timer and four font-rendered text regions.
// Latency: pixel inputs at cycle n produce text_on/text_rgb at cycle n+1 (aligned to the registered font read).
// Backpressure: none; one pixel per clock, and the control inputs are sampled every cycle.

module hud_text_overlay #(
  parameter int         CLK_FREQ     = 25_000_000,
  parameter int         TIMER_MIN    = 3,
  parameter int         TIMER_SEC    = 0,
  parameter logic [2:0] FG_RGB       = 3'b000,
  parameter logic [2:0] BG_RGB       = 3'b111,
  parameter bit         PROMPT_BLINK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_on,
  input  logic       start,
  input  logic       player_dead,
  input  logic       pause,
  output logic [3:0] text_on,
  output logic [2:0] text_rgb,
  output logic [1:0] game_state,
  output logic       time_up
);

  localparam int            HALF      = CLK_FREQ / 2;
  localparam int            PW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF - 1);
  localparam logic [3:0]    PRE_M     = 4'(TIMER_MIN);
  localparam logic [3:0]    PRE_S10   = 4'(TIMER_SEC / 10);
  localparam logic [3:0]    PRE_S1    = 4'(TIMER_SEC % 10);

  localparam logic [1:0] ST_TITLE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] presc;
  logic          sec_phase, blink;
  logic [3:0]    tm_m, tm_s10, tm_s1;
  logic          run, half_tick, sec_tick, load_game, timer_zero, expire;
  logic          score_en, title_en, prompt_en, over_en;
  logic          score_hit, title_hit, prompt_hit, over_hit;
  logic [3:0]    title_col;
  logic [4:0]    over_col;
  logic [6:0]    score_char, title_char, prompt_char, over_char, char_sel;
  logic [3:0]    row_sel;
  logic [2:0]    bit_sel, bit1;
  logic [10:0]   rom_addr;
  logic [7:0]    font_word;
  logic [3:0]    flags1;
  logic          vo1;

  // The prescaler is frozen only while paused mid-game; a new game restarts it from zero.
  assign run        = !(state == ST_PLAY && pause);
  assign half_tick  = run && (presc == HALF_LAST);
  assign sec_tick   = half_tick && sec_phase;
  assign load_game  = (state == ST_TITLE) && start;
  assign timer_zero = (tm_m == 4'd0) && (tm_s10 == 4'd0) && (tm_s1 == 4'd0);
  assign expire     = (state == ST_PLAY) && sec_tick &&
                      (tm_m == 4'd0) && (tm_s10 == 4'd0) && (tm_s1 == 4'd1);

  // FSM state register; reset dominates a coincident start.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_TITLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic; the unused encoding falls back to TITLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_TITLE: if (start)                state_nxt = ST_PLAY;
      ST_PLAY:  if (player_dead || expire) state_nxt = ST_OVER;
      ST_OVER:  if (start)                state_nxt = ST_TITLE;
      default:                            state_nxt = ST_TITLE;
    endcase
  end

  // FSM outputs: which text regions may appear in the current phase.
  always_comb begin
    game_state = state;
    score_en   = (state == ST_PLAY) || (state == ST_OVER);
    title_en   = (state == ST_TITLE);
    prompt_en  = ((state == ST_TITLE) || (state == ST_OVER)) && (blink || !PROMPT_BLINK);
    over_en    = (state == ST_OVER);
  end

  // Half-second prescaler plus the phase bit that turns every second half-tick into a second-tick.
  always_ff @(posedge clk) begin
    if (reset || load_game) begin
      presc     <= '0;
      sec_phase <= 1'b0;
    end else if (run) begin
      if (presc == HALF_LAST) begin
        presc     <= '0;
        sec_phase <= ~sec_phase;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // BCD countdown; it parks at 0:00 and pulses time_up together with the move to OVER.
  always_ff @(posedge clk) begin
    if (reset) begin
      tm_m    <= PRE_M;
      tm_s10  <= PRE_S10;
      tm_s1   <= PRE_S1;
      time_up <= 1'b0;
    end else begin
      time_up <= expire;
      if (load_game) begin
        tm_m   <= PRE_M;
        tm_s10 <= PRE_S10;
        tm_s1  <= PRE_S1;
      end else if (state == ST_PLAY && sec_tick && !timer_zero) begin
        if (tm_s1 != 4'd0) begin
          tm_s1 <= tm_s1 - 4'd1;
        end else begin
          tm_s1 <= 4'd9;
          if (tm_s10 != 4'd0) begin
            tm_s10 <= tm_s10 - 4'd1;
          end else begin
            tm_s10 <= 4'd5;
            tm_m   <= tm_m - 4'd1;
          end
        end
      end
    end
  end

  // Prompt blink phase: starts lit whenever TITLE or OVER is entered, then toggles each half-second.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink <= 1'b1;
    end else if (state_nxt != state && (state_nxt == ST_TITLE || state_nxt == ST_OVER)) begin
      blink <= 1'b1;
    end else if (half_tick && (state == ST_TITLE || state == ST_OVER)) begin
      blink <= ~blink;
    end
  end

  assign title_col  = pix_x[9:6] - 4'd3;
  assign over_col   = pix_x[9:5] - 5'd5;
  assign score_hit  = score_en && (pix_y < 10'd32) && (pix_x < 10'd64);
  assign title_hit  = title_en && (pix_y[9:7] == 3'd2) && (pix_x[9:6] >= 4'd3) && (pix_x[9:6] <= 4'd6);
  assign prompt_hit = prompt_en && (pix_y[9:4] == 6'd28) && (pix_x[9:7] == 3'd2);
  assign over_hit   = over_en && (pix_y[9:6] == 4'd3) && (pix_x[9:5] >= 5'd5) && (pix_x[9:5] <= 5'd13);

  // Character codes for each region's current column.
  always_comb begin
    case (pix_x[5:4])
      2'd0:    score_char = {3'b011, tm_m};
      2'd1:    score_char = 7'h3a;
      2'd2:    score_char = {3'b011, tm_s10};
      default: score_char = {3'b011, tm_s1};
    endcase
    case (title_col)
      4'd0:    title_char = 7'h44;
      4'd1:    title_char = 7'h4f;
      4'd2:    title_char = 7'h4f;
      default: title_char = 7'h4d;
    endcase
    case (pix_x[6:3])
      4'd0:  prompt_char = 7'h50;  4'd1:  prompt_char = 7'h72;
      4'd2:  prompt_char = 7'h65;  4'd3:  prompt_char = 7'h73;
      4'd4:  prompt_char = 7'h73;  4'd5:  prompt_char = 7'h20;
      4'd6:  prompt_char = 7'h74;  4'd7:  prompt_char = 7'h6f;
      4'd8:  prompt_char = 7'h20;  4'd9:  prompt_char = 7'h73;
      4'd10: prompt_char = 7'h74;  4'd11: prompt_char = 7'h61;
      4'd12: prompt_char = 7'h72;  4'd13: prompt_char = 7'h74;
      4'd14: prompt_char = 7'h2e;  default: prompt_char = 7'h00;
    endcase
    case (over_col)
      5'd0: over_char = 7'h47;  5'd1: over_char = 7'h61;
      5'd2: over_char = 7'h6d;  5'd3: over_char = 7'h65;
      5'd5: over_char = 7'h4f;  5'd6: over_char = 7'h76;
      5'd7: over_char = 7'h65;  5'd8: over_char = 7'h72;
      default: over_char = 7'h00;
    endcase
  end

  // Font address mux, priority title > prompt > score > over; each font scales the glyph differently.
  always_comb begin
    char_sel = 7'h00;
    row_sel  = 4'h0;
    bit_sel  = 3'h0;
    if (title_hit) begin
      char_sel = title_char;  row_sel = pix_y[6:3]; bit_sel = pix_x[5:3];
    end else if (prompt_hit) begin
      char_sel = prompt_char; row_sel = pix_y[3:0]; bit_sel = pix_x[2:0];
    end else if (score_hit) begin
      char_sel = score_char;  row_sel = pix_y[4:1]; bit_sel = pix_x[3:1];
    end else if (over_hit) begin
      char_sel = over_char;   row_sel = pix_y[5:2]; bit_sel = pix_x[4:2];
    end
  end

  assign rom_addr = {char_sel, row_sel};

  font_rom u_font (
    .clk  (clk),
    .addr (rom_addr),
    .data (font_word)
  );

  // Stage 1: hold flags, bit select and blanking alongside the one-cycle font read.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags1 <= 4'b0000;
      bit1   <= 3'd0;
      vo1    <= 1'b0;
    end else begin
      flags1 <= {score_hit, title_hit, prompt_hit, over_hit};
      bit1   <= bit_sel;
      vo1    <= video_on;
    end
  end

  // Colour select; glyph rows are stored MSB-leftmost, hence the inverted bit index.
  always_comb begin
    text_on  = vo1 ? flags1 : 4'b0000;
    text_rgb = (vo1 && (flags1 != 4'b0000) && font_word[~bit1]) ? FG_RGB : BG_RGB;
  end

endmodule

// Font ROM: 128 characters x 16 rows x 8 pixels, MSB is the leftmost pixel.
// Latency: one cycle (registered read).
// Stand-in contents (deterministic pattern) for standalone builds; the project font image replaces this body.
module font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  // Registered read.
  always_ff @(posedge clk) begin
    data <= {addr[3:0], addr[3:0]} ^ addr[10:3];
  end

endmodule

// File: tb/tb_hud_text_overlay.sv
// Bench for hud_text_overlay with an 8 Hz clock so one second is 8 cycles.
// Pixel expectations go into a scoreboard queue when driven and are popped one cycle later.
// Control-path checks use constants derived from the cycle count since game start.

module tb_hud_text_overlay;

  localparam logic [2:0] FG = 3'b000;
  localparam logic [2:0] BG = 3'b111;

  logic       clk = 1'b0;
  logic       reset, video_on, start, player_dead, pause;
  logic [9:0] pix_x, pix_y;
  logic [3:0] text_on;
  logic [2:0] text_rgb;
  logic [1:0] game_state;
  logic       time_up;

  always #5 clk = ~clk;

  hud_text_overlay #(
    .CLK_FREQ(8), .TIMER_MIN(3), .TIMER_SEC(0),
    .FG_RGB(FG), .BG_RGB(BG), .PROMPT_BLINK(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .start(start), .player_dead(player_dead), .pause(pause),
    .text_on(text_on), .text_rgb(text_rgb), .game_state(game_state), .time_up(time_up)
  );

  typedef struct {
    logic [3:0] on;
    logic [2:0] rgb;
    string      name;
  } exp_t;

  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    tu_count = 0;
  int    base = 0;
  string prompt_txt = "Press to start.";
  string title_txt = "DOOM";
  byte   over_txt[9] = '{8'h47, 8'h61, 8'h6d, 8'h65, 8'h00, 8'h4f, 8'h76, 8'h65, 8'h72};

  always @(negedge clk) if (time_up === 1'b1) tu_count++;

  function automatic logic [7:0] glyph(logic [10:0] a);
    return {a[3:0], a[3:0]} ^ a[10:3];
  endfunction

  // Reference for one pixel: {text_on, text_rgb}.
  function automatic logic [6:0] model_px(int x, int y, bit vo, int st, bit blink, int m, int s10, int s1);
    bit sc, ti, pr, ov;
    int ch, row, bt, idx;
    logic [7:0] w;
    logic [3:0] on;
    logic [2:0] rgb;
    sc = (st == 1 || st == 2) && y < 32 && x < 64;
    ti = (st == 0) && (y / 128 == 2) && (x / 64 >= 3) && (x / 64 <= 6);
    pr = (st == 0 || st == 2) && blink && (y / 16 == 28) && (x / 128 == 2);
    ov = (st == 2) && (y / 64 == 3) && (x / 32 >= 5) && (x / 32 <= 13);
    ch = 0; row = 0; bt = 0;
    if (ti) begin
      ch = title_txt[x / 64 - 3]; row = (y / 8) % 16; bt = (x / 8) % 8;
    end else if (pr) begin
      idx = (x / 8) % 16;
      ch = (idx < 15) ? prompt_txt[idx] : 0; row = y % 16; bt = x % 8;
    end else if (sc) begin
      case (x / 16)
        0: ch = 48 + m;
        1: ch = 58;
        2: ch = 48 + s10;
        default: ch = 48 + s1;
      endcase
      row = (y / 2) % 16; bt = (x / 2) % 8;
    end else if (ov) begin
      ch = over_txt[x / 32 - 5]; row = (y / 4) % 16; bt = (x / 4) % 8;
    end
    w = glyph(11'(ch * 16 + row));
    on = vo ? {sc, ti, pr, ov} : 4'b0000;
    rgb = (vo && on != 4'b0000 && w[7 - bt]) ? FG : BG;
    return {on, rgb};
  endfunction

  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_px(int x, int y, bit vo, int st, int m, int s10, int s1, string nm);
    exp_t e;
    logic [6:0] r;
    pix_x = 10'(x); pix_y = 10'(y); video_on = vo;
    r = model_px(x, y, vo, st, 1'b1, m, s10, s1);
    e.on = r[6:3]; e.rgb = r[2:0]; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b1; start = 1'b0; player_dead = 1'b0; pause = 1'b0;
    video_on = 1'b1; pix_x = 10'd0; pix_y = 10'd0;
    repeat (3) tick;
    n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", game_state); end
    n_cmp++; if (text_on !== 4'b0000) begin n_bad++; $display("FAIL reset_text_on: got %b want 0000", text_on); end
    n_cmp++; if (text_rgb !== BG) begin n_bad++; $display("FAIL reset_rgb: got %b want %b", text_rgb, BG); end
    n_cmp++; if (time_up !== 1'b0) begin n_bad++; $display("FAIL reset_time_up: got %b want 0", time_up); end
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h300) begin n_bad++;
      $display("FAIL reset_timer: got %h want 300", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
    start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("FAIL start_during_reset: got %0d want 0", game_state); end
    reset = 1'b0;
    drive_px(200, 300, 1'b1, 0, 3, 0, 0, "title_pixel");
    tick;
    e = exp_q.pop_front();
    n_cmp++; if (text_on !== e.on || text_rgb !== e.rgb) begin n_bad++;
      $display("FAIL %s: got %b/%b want %b/%b", e.name, text_on, text_rgb, e.on, e.rgb); end
    n_cmp++; if (text_on !== 4'b0100) begin n_bad++; $display("FAIL title_flag: got %b want 0100", text_on); end
    drive_px(0, 0, 1'b1, 0, 3, 0, 0, "title_blank");
    tick;
    e = exp_q.pop_front();
    n_cmp++; if (text_on !== e.on || text_rgb !== e.rgb) begin n_bad++;
      $display("FAIL %s: got %b/%b want %b/%b", e.name, text_on, text_rgb, e.on, e.rgb); end
    drive_px(200, 300, 1'b0, 0, 3, 0, 0, "video_off");
    tick;
    e = exp_q.pop_front();
    n_cmp++; if (text_on !== e.on || text_rgb !== e.rgb) begin n_bad++;
      $display("FAIL %s: got %b/%b want %b/%b", e.name, text_on, text_rgb, e.on, e.rgb); end
  endtask

  task automatic test_start_countdown;
    start = 1'b1;
    tick;
    start = 1'b0;
    base = cyc;
    n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("FAIL start_to_play: got %0d want 1", game_state); end
    while (cyc < base + 7) tick;
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h300) begin n_bad++;
      $display("FAIL timer_before_first_sec: got %h want 300", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
    tick;
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h259) begin n_bad++;
      $display("FAIL timer_first_sec: got %h want 259", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
  endtask

  task automatic test_score_sweep;
    exp_t e;
    for (int x = 16; x < 32; x++) begin
      drive_px(x, 2, 1'b1, 1, 0, 0, 0, "score_colon");
      #1;
      n_cmp++; if (dut.rom_addr !== 11'h3a1) begin n_bad++;
        $display("FAIL score_rom_addr x=%0d: got %h want 3a1", x, dut.rom_addr); end
      tick;
      e = exp_q.pop_front();
      n_cmp++; if (text_on !== e.on || text_rgb !== e.rgb) begin n_bad++;
        $display("FAIL %s x=%0d: got %b/%b want %b/%b", e.name, x, text_on, text_rgb, e.on, e.rgb); end
    end
    pix_x = 10'd0; pix_y = 10'd100;
  endtask

  task automatic test_expiry;
    int tu0;
    tu0 = tu_count;
    while (cyc < base + 1439) tick;
    n_cmp++; if (time_up !== 1'b0 || game_state !== 2'd1) begin n_bad++;
      $display("FAIL pre_expiry: time_up=%b state=%0d want 0/1", time_up, game_state); end
    tick;
    n_cmp++; if (time_up !== 1'b1) begin n_bad++; $display("FAIL expiry_time_up: got %b want 1", time_up); end
    n_cmp++; if (game_state !== 2'd2) begin n_bad++; $display("FAIL expiry_state: got %0d want 2", game_state); end
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h000) begin n_bad++;
      $display("FAIL expiry_timer: got %h want 000", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
    repeat (9) tick;
    n_cmp++; if (tu_count - tu0 !== 1) begin n_bad++; $display("FAIL expiry_pulse_count: got %0d want 1", tu_count - tu0); end
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h000) begin n_bad++;
      $display("FAIL timer_no_underflow: got %h want 000", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
  endtask

  task automatic test_over_blink;
    exp_t e;
    int prev, last_t, ntog;
    drive_px(165, 200, 1'b1, 2, 0, 0, 0, "over_text");
    tick;
    e = exp_q.pop_front();
    n_cmp++; if (text_on !== e.on || text_rgb !== e.rgb) begin n_bad++;
      $display("FAIL %s: got %b/%b want %b/%b", e.name, text_on, text_rgb, e.on, e.rgb); end
    drive_px(40, 10, 1'b1, 2, 0, 0, 0, "score_in_over");
    tick;
    e = exp_q.pop_front();
    n_cmp++; if (text_on !== e.on || text_rgb !== e.rgb) begin n_bad++;
      $display("FAIL %s: got %b/%b want %b/%b", e.name, text_on, text_rgb, e.on, e.rgb); end
    pix_x = 10'd260; pix_y = 10'd450; video_on = 1'b1;
    tick;
    prev = -1; last_t = -1; ntog = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (prev != -1 && int'(text_on[1]) != prev) begin
        if (last_t >= 0) begin
          n_cmp++; if (cyc - last_t != 4) begin n_bad++;
            $display("FAIL blink_period: got %0d want 4", cyc - last_t); end
        end
        last_t = cyc;
        ntog++;
      end
      prev = int'(text_on[1]);
    end
    n_cmp++; if (ntog < 6) begin n_bad++; $display("FAIL blink_toggles: got %0d want >=6", ntog); end
  endtask

  task automatic test_start_cycle;
    start = 1'b1; tick; start = 1'b0;
    n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("FAIL over_to_title: got %0d want 0", game_state); end
    tick;
    start = 1'b1; tick; start = 1'b0;
    base = cyc;
    n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("FAIL title_to_play: got %0d want 1", game_state); end
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h300) begin n_bad++;
      $display("FAIL timer_reload: got %h want 300", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
  endtask

  task automatic test_pause_dead;
    int tu0;
    tu0 = tu_count;
    while (cyc < base + 3) tick;
    pause = 1'b1;
    repeat (40) tick;
    pause = 1'b0;
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h300) begin n_bad++;
      $display("FAIL pause_hold: got %h want 300", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
    while (cyc < base + 47) tick;
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h300) begin n_bad++;
      $display("FAIL pause_shift: got %h want 300", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
    tick;
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h259) begin n_bad++;
      $display("FAIL after_pause_sec: got %h want 259", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
    while (cyc < base + 60) tick;
    start = 1'b1; tick; start = 1'b0;
    n_cmp++; if (game_state !== 2'd1 || {dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h258) begin n_bad++;
      $display("FAIL start_in_play: state=%0d timer=%h want 1/258", game_state, {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
    while (cyc < base + 1479) tick;
    n_cmp++; if (time_up !== 1'b0 || game_state !== 2'd1) begin n_bad++;
      $display("FAIL pre_dead_expiry: time_up=%b state=%0d want 0/1", time_up, game_state); end
    player_dead = 1'b1;
    tick;
    player_dead = 1'b0;
    n_cmp++; if (time_up !== 1'b1 || game_state !== 2'd2) begin n_bad++;
      $display("FAIL dead_and_expiry: time_up=%b state=%0d want 1/2", time_up, game_state); end
    repeat (3) tick;
    n_cmp++; if (tu_count - tu0 !== 1) begin n_bad++; $display("FAIL dead_pulse_count: got %0d want 1", tu_count - tu0); end
  endtask

  task automatic test_reset_midplay;
    test_start_cycle;
    while (cyc < base + 776) tick;
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h123) begin n_bad++;
      $display("FAIL reach_1_23: got %h want 123", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
    pix_x = 10'd20; pix_y = 10'd2; video_on = 1'b1;
    reset = 1'b1; start = 1'b1;
    tick;
    reset = 1'b0; start = 1'b0;
    n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("FAIL midplay_reset_state: got %0d want 0", game_state); end
    n_cmp++; if ({dut.tm_m, dut.tm_s10, dut.tm_s1} !== 12'h300) begin n_bad++;
      $display("FAIL midplay_reset_timer: got %h want 300", {dut.tm_m, dut.tm_s10, dut.tm_s1}); end
    n_cmp++; if (time_up !== 1'b0 || text_on !== 4'b0000 || text_rgb !== BG) begin n_bad++;
      $display("FAIL midplay_reset_out: time_up=%b text_on=%b rgb=%b want 0/0000/%b", time_up, text_on, text_rgb, BG); end
  endtask

  initial begin
    test_reset;
    test_start_countdown;
    test_score_sweep;
    test_expiry;
    test_over_blink;
    test_start_cycle;
    test_pause_dead;
    test_reset_midplay;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
